// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
//   state_e : arbiter FSM states (IDLE/BUSY/DONE)
//   port_e  : requester IDs, PORT_IF = fetch (port 1), PORT_MEM = data (port 2)
//   DEF_*   : default widths and tuning values
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_MEM = 1'b1
  } port_e;

  localparam int unsigned DEF_AW         = 64;
  localparam int unsigned DEF_DW         = 64;
  localparam int unsigned DEF_MAX_STREAK = 4;
  localparam int unsigned DEF_TIMEOUT    = 15;

endpackage

// File: rtl/mem_arb_wdog.sv
// Slave-timeout watchdog for the memory arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count from zero (has priority over en)
//   en         : count one waiting cycle
//   expired    : count has reached TIMEOUT (count saturates there)
module mem_arb_wdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequential two-master arbiter for the shared memory port.
// Port 1 is instruction fetch, port 2 is memory access. Port 2 has priority,
// but after MAX_STREAK consecutive port-2 grants while fetch waits, fetch wins.
//   CLK, RESET                : clock, asynchronous active-low reset
//   HTRANS_x/HADDR_x/HWRITE_x/HWDATA_x : requests, held until HREADY_x
//   HRDATA_x/HREADY_x/HERR_x  : registered response, one-cycle HREADY pulse
//   S_REQ/S_ADDR/S_WRITE/S_WDATA : registered slave request
//   S_RDATA/S_READY           : slave response
//   stall                     : combined pipeline stall (combinational)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned MAX_STREAK = DEF_MAX_STREAK,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          HTRANS_1,
  input  logic [AW-1:0] HADDR_1,
  input  logic          HWRITE_1,
  input  logic [DW-1:0] HWDATA_1,
  output logic [DW-1:0] HRDATA_1,
  output logic          HREADY_1,
  output logic          HERR_1,
  input  logic          HTRANS_2,
  input  logic [AW-1:0] HADDR_2,
  input  logic          HWRITE_2,
  input  logic [DW-1:0] HWDATA_2,
  output logic [DW-1:0] HRDATA_2,
  output logic          HREADY_2,
  output logic          HERR_2,
  output logic          S_REQ,
  output logic [AW-1:0] S_ADDR,
  output logic          S_WRITE,
  output logic [DW-1:0] S_WDATA,
  input  logic [DW-1:0] S_RDATA,
  input  logic          S_READY,
  output logic          stall
);

  localparam int unsigned SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;

  state_e        state;
  port_e         owner;
  port_e         sel;
  logic [SW-1:0] streak;
  logic          any_req;
  logic          streak_full;
  logic          wd_clr;
  logic          wd_en;
  logic          wd_expired;

  assign any_req     = HTRANS_1 | HTRANS_2;
  assign streak_full = (streak == SW'(MAX_STREAK));
  assign stall       = (HTRANS_1 & ~HREADY_1) | (HTRANS_2 & ~HREADY_2);

  always_comb begin
    sel = PORT_IF;
    if (HTRANS_2 && !(HTRANS_1 && streak_full)) begin
      sel = PORT_MEM;
    end
  end

  assign wd_clr = (state == IDLE) && any_req;
  assign wd_en  = (state == BUSY) && !S_READY;

  mem_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (CLK),
    .rst_n  (RESET),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      owner    <= PORT_IF;
      streak   <= '0;
      S_REQ    <= 1'b0;
      S_WRITE  <= 1'b0;
      S_ADDR   <= '0;
      S_WDATA  <= '0;
      HRDATA_1 <= '0;
      HRDATA_2 <= '0;
      HREADY_1 <= 1'b0;
      HREADY_2 <= 1'b0;
      HERR_1   <= 1'b0;
      HERR_2   <= 1'b0;
    end else begin
      // Completion flags are pulses: asserted only on the edge entering DONE.
      HREADY_1 <= 1'b0;
      HREADY_2 <= 1'b0;
      HERR_1   <= 1'b0;
      HERR_2   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= sel;
            S_REQ <= 1'b1;
            state <= BUSY;
            if (sel == PORT_MEM) begin
              S_ADDR  <= HADDR_2;
              S_WRITE <= HWRITE_2;
              S_WDATA <= HWDATA_2;
              if (!HTRANS_1) begin
                streak <= '0;
              end else if (!streak_full) begin
                streak <= streak + 1'b1;
              end
            end else begin
              S_ADDR  <= HADDR_1;
              S_WRITE <= HWRITE_1;
              S_WDATA <= HWDATA_1;
              streak  <= '0;
            end
          end
        end
        BUSY: begin
          // S_READY is checked first so a response in the timeout cycle wins.
          if (S_READY) begin
            S_REQ <= 1'b0;
            state <= DONE;
            if (owner == PORT_MEM) begin
              HREADY_2 <= 1'b1;
              if (!S_WRITE) HRDATA_2 <= S_RDATA;
            end else begin
              HREADY_1 <= 1'b1;
              if (!S_WRITE) HRDATA_1 <= S_RDATA;
            end
          end else if (wd_expired) begin
            S_REQ <= 1'b0;
            state <= DONE;
            if (owner == PORT_MEM) begin
              HREADY_2 <= 1'b1;
              HERR_2   <= 1'b1;
            end else begin
              HREADY_1 <= 1'b1;
              HERR_1   <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential two-master arbiter that shares the single memory/ROM port between the instruction-fetch stage (port 1) and the memory-access stage (port 2). It replaces the combinational address mux with a registered request/ready handshake, fixed data-port priority with fetch anti-starvation, a slave-timeout watchdog and a combined pipeline stall. It sits between `inst_fetch`/`mem_access` and the memory slave inside `cpu_top`.

## Interface
- `AW`, 64, address width.
- `DW`, 64, data width.
- `MAX_STREAK`, 4, consecutive data-port grants allowed while fetch is waiting.
- `TIMEOUT`, 15, cycles in BUSY without `S_READY` before abort (≥1).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: reset, asynchronous, active-low.
- `HTRANS_1`, `HTRANS_2` in 1: request valid, held until the matching `HREADY_x`.
- `HADDR_1`, `HADDR_2` in AW: request address.
- `HWRITE_1`, `HWRITE_2` in 1: 1 = write.
- `HWDATA_1`, `HWDATA_2` in DW: write data.
- `HRDATA_1`, `HRDATA_2` out DW: registered read data, valid when `HREADY_x`=1.
- `HREADY_1`, `HREADY_2` out 1: one-cycle completion pulse.
- `HERR_1`, `HERR_2` out 1: with `HREADY_x`, the transfer timed out.
- `S_REQ` out 1, `S_ADDR` out AW, `S_WRITE` out 1, `S_WDATA` out DW: slave request, registered.
- `S_RDATA` in DW, `S_READY` in 1: slave response.
- `stall` out 1: `(HTRANS_1 & ~HREADY_1) | (HTRANS_2 & ~HREADY_2)`, combinational.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any `HTRANS_x`=1, select owner, latch addr/write/wdata into `S_*`, set `S_REQ`=1, clear watchdog, go to BUSY. Otherwise stay.
- Selection: port 2 wins, unless `HTRANS_1`=1 and `streak`==MAX_STREAK, in which case port 1 wins. With only one requester active, that requester wins.
- Streak update: a port-2 grant while `HTRANS_1`=1 increments `streak` (saturating at MAX_STREAK). A port-2 grant with `HTRANS_1`=0 clears it. A port-1 grant clears it.
- BUSY: `S_*` held stable and `S_REQ`=1.
  - On `S_READY`=1: capture `S_RDATA` into owner's `HRDATA_x` (reads only; writes leave it unchanged), clear `S_REQ`, go to DONE.
  - Otherwise the watchdog increments. When watchdog==TIMEOUT, clear `S_REQ`, set owner's error flag, go to DONE.
  - `S_READY` in the timeout cycle counts as success.
- DONE: owner's `HREADY_x`=1 (and `HERR_x` if flagged) for exactly one cycle, then return to IDLE. Requests are not sampled in DONE.
- `S_READY` outside BUSY is ignored.
- Requester changes to HADDR/HWDATA while BUSY have no effect. Dropping `HTRANS_x` mid-transfer does not abort it; `HREADY_x` still pulses.
- Asynchronous reset at any point: state=IDLE; `S_REQ`, `S_WRITE`, `HREADY_x`, `HERR_x`=0; `S_ADDR`, `S_WDATA`, `HRDATA_x`=0; `streak`=0; watchdog=0. Any in-flight transfer is dropped silently.

## Timing
- Request sampled in IDLE at edge N; `S_REQ`=1 from cycle N+1.
- With `S_READY` in cycle N+1: DONE and `HREADY_x` in cycle N+2.
- Minimum of 3 cycles per transfer. Back-to-back: next grant at the IDLE cycle N+3.
- Timeout: `HREADY_x`+`HERR_x` at cycle N+TIMEOUT+2.
- `HRDATA_x` holds its value until the next read completion on that port.
- `stall` has zero latency from `HTRANS_x`. It falls in the `HREADY_x` cycle, so the stage advances on that edge.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/BUSY/DONE), port IDs `PORT_IF`=0 and `PORT_MEM`=1, default widths.
- One sub-module, `mem_arb_wdog`, containing the watchdog counter with clear/enable inputs and an `expired` output.
- Arbitration, streak and datapath registers live in `mem_arbiter`.

## Test plan
- Single fetch read: `HTRANS_1`=1, `HADDR_1`=0x40, slave `S_READY` the cycle after `S_REQ`, `S_RDATA`=0x13 → `S_ADDR`=0x40 at N+1, `HREADY_1`=1 and `HRDATA_1`=0x13 at N+2, `stall`=1 for N..N+1.
- Simultaneous requests at IDLE (both `HTRANS`=1) → port 2 served first, port 1 completes on the next transfer with `HREADY_1` at N+5.
- Anti-starvation: `HTRANS_2` held for 10 transfers with `HTRANS_1`=1 → grant order 2,2,2,2,1,2,2,2,2,1.
- Timeout: `S_READY` never asserted with TIMEOUT=15 → `HREADY_2`=`HERR_2`=1 at N+17, `S_REQ`=0 from N+17, next request accepted.
- Write: `HWRITE_2`=1, `HWDATA_2`=0xDEADBEEF → `S_WRITE`=1 and `S_WDATA`=0xDEADBEEF while BUSY, `HRDATA_2` unchanged.
- Reset asserted mid-BUSY → all outputs 0 asynchronously; after release no `HREADY` pulse appears for the dropped transfer.
